// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: framer state encoding and line levels.
// Imported by the FIFO transmitter top and reusable by the planned receiver.
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-port and status bundle between register/readout logic (master) and uart_tx_fifo (slave).
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned FIFO_AW = 4
);
   logic              ld_tx_data;
   logic [DATA_W-1:0] tx_data;
   logic              tx_enable;
   logic              tx_out;
   logic              tx_empty;
   logic              tx_full;
   logic [FIFO_AW:0]  tx_count;
   logic              overflow;

   modport master (
      output ld_tx_data, tx_data, tx_enable,
      input  tx_out, tx_empty, tx_full, tx_count, overflow
   );

   modport slave (
      input  ld_tx_data, tx_data, tx_enable,
      output tx_out, tx_empty, tx_full, tx_count, overflow
   );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and full/empty flags.
// Shared with the planned receiver; writes while full and reads while empty are ignored.
module uart_sync_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_wr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd,
   output logic [DW-1:0] o_rd_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);
   localparam int unsigned DEPTH      = 1 << AW;
   localparam logic [AW:0] COUNT_FULL = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_wr_en;
   logic          w_rd_en;

   // Full is judged on the registered count, so a same-cycle read never frees a slot for a write.
   assign w_wr_en   = i_wr & ~o_full;
   assign w_rd_en   = i_rd & ~o_empty;
   assign o_full    = (r_count == COUNT_FULL);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: configurable data width, stop bits and baud divider.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_AW      = 4,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
);
`ifdef UART_TX_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
`else
   localparam bit HAS_PARITY = 1'b0;
`endif

   localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned       BIT_W     = $clog2(DATA_W);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t         r_state,  w_state_nxt;
   logic [BAUD_W-1:0] r_baud,   w_baud_nxt;
   logic [BIT_W-1:0]  r_bit,    w_bit_nxt;
   logic              r_stop,   w_stop_nxt;
   logic [DATA_W-1:0] r_shift,  w_shift_nxt;
   logic              r_parity, w_parity_nxt;
   logic              r_tx_out;
   logic              r_overflow;
   logic              w_line;
   logic              w_pop;
   logic              w_baud_end;
   logic [DATA_W-1:0] w_head;
   logic [FIFO_AW:0]  w_count;
   logic              w_full;
   logic              w_fifo_empty;

   uart_sync_fifo #(
      .DW (DATA_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (bus.ld_tx_data),
      .i_wr_data (bus.tx_data),
      .i_rd      (w_pop),
      .o_rd_data (w_head),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_fifo_empty)
   );

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = r_baud + 1'b1;
      w_bit_nxt    = r_bit;
      w_stop_nxt   = r_stop;
      w_shift_nxt  = r_shift;
      w_parity_nxt = r_parity;
      w_pop        = 1'b0;
      w_line       = LINE_IDLE;
      if (w_baud_end) begin
         w_baud_nxt = '0;
      end
      case (r_state)
         ST_IDLE: begin
            w_baud_nxt = '0;
            if (bus.tx_enable && !w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            w_line = 1'b0;
            if (w_baud_end) begin
               w_bit_nxt   = '0;
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            w_line = r_shift[0];
            if (w_baud_end) begin
               w_shift_nxt = r_shift >> 1;
               w_bit_nxt   = r_bit + 1'b1;
               if (r_bit == BIT_LAST) begin
                  w_stop_nxt  = 1'b0;
                  w_state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            w_line = r_parity;
            if (w_baud_end) begin
               w_stop_nxt  = 1'b0;
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_baud_end) begin
               if (r_stop == STOP_LAST) begin
                  // Chain straight into the next start bit so queued frames leave no idle gap.
                  if (bus.tx_enable && !w_fifo_empty) begin
                     w_pop       = 1'b1;
                     w_state_nxt = ST_START;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_stop_nxt = r_stop + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_pop) begin
         w_shift_nxt  = w_head;
         w_parity_nxt = (^w_head) ^ (PARITY_ODD != 0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_stop     <= 1'b0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx_out   <= LINE_IDLE;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit      <= w_bit_nxt;
         r_stop     <= w_stop_nxt;
         r_shift    <= w_shift_nxt;
         r_parity   <= w_parity_nxt;
         r_tx_out   <= w_line;
         r_overflow <= r_overflow | (bus.ld_tx_data & w_full);
      end
   end

   assign bus.tx_out   = r_tx_out;
   assign bus.tx_empty = w_fifo_empty && (r_state == ST_IDLE);
   assign bus.tx_full  = w_full;
   assign bus.tx_count = w_count;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle-exact vector table for one frame, a line
// decoder scoreboard for every transmitted word, and directed sequences for the corner cases.
module tb_uart_tx_fifo;
   localparam int unsigned DW  = 8;
   localparam int unsigned CPB = 4;
   localparam int unsigned SB  = 1;
   localparam int unsigned AW  = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned PB  = 1;
`else
   localparam int unsigned PB  = 0;
`endif
   localparam int unsigned NB    = 1 + DW + PB + SB;
   localparam int unsigned FRAME = NB * CPB;
   localparam int unsigned N_VEC = FRAME + 4;

   typedef struct {
      logic        ld;
      logic [7:0]  data;
      logic        en;
      logic        exp_out;
      logic        exp_empty;
      logic [4:0]  exp_count;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [7:0]  exp_q[$];
   int unsigned start_q[$];
   vec_t        vec[N_VEC];

   uart_tx_fifo_if #(.DATA_W(DW), .FIFO_AW(AW)) bus();

   uart_tx_fifo #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB),
      .FIFO_AW      (AW),
      .PARITY_ODD   (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

`ifdef UART_TX_PARITY_EN
   uart_tx_fifo_if #(.DATA_W(DW), .FIFO_AW(AW)) bus2();
   assign bus2.ld_tx_data = bus.ld_tx_data;
   assign bus2.tx_data    = bus.tx_data;
   assign bus2.tx_enable  = bus.tx_enable;

   uart_tx_fifo #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB),
      .FIFO_AW      (AW),
      .PARITY_ODD   (1)
   ) dut_odd (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] d, input bit accept);
      bus.ld_tx_data = 1'b1;
      bus.tx_data    = d;
      tick();
      bus.ld_tx_data = 1'b0;
      if (accept) exp_q.push_back(d);
   endtask

   task automatic wait_empty(input int unsigned maxc, input string name);
      int unsigned n;
      n = 0;
      while (bus.tx_empty !== 1'b1 && n < maxc) begin
         tick();
         n++;
      end
      check(name, bus.tx_empty, 1'b1);
   endtask

   // Line decoder: samples each bit mid-period after a falling edge and scores the word.
   initial begin : monitor
      logic        prev;
      logic [15:0] bits;
      logic [7:0]  d;
      bit          aborted;
      int unsigned pos;
      prev = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (reset && prev && !bus.tx_out) begin
            start_q.push_back(cyc);
            aborted = 1'b0;
            pos = 0;
            bits = '1;
            for (int b = 0; b < NB; b++) begin
               while (pos < b * CPB + CPB / 2) begin
                  @(posedge clk);
                  #2;
                  pos++;
                  if (!reset) aborted = 1'b1;
               end
               bits[b] = bus.tx_out;
            end
            if (!aborted) begin
               d = bits[8:1];
               check("start_bit", bits[0], 1'b0);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL frame_unexpected: got 0x%0h, expected no frame", d);
               end else begin
                  check("frame_data", d, exp_q.pop_front());
               end
`ifdef UART_TX_PARITY_EN
               check("parity_bit", bits[1+DW], ^d);
`endif
               check("stop_bit", bits[NB-1], 1'b1);
            end
         end
         prev = bus.tx_out;
      end
   end

   initial begin : main
      logic [15:0] fb;
      logic [7:0]  d;
      int unsigned lows;
      int unsigned n;

      bus.ld_tx_data = 1'b0;
      bus.tx_data    = '0;
      bus.tx_enable  = 1'b0;
      reset          = 1'b0;
      tick();
      tick();
      check("rst_tx_out", bus.tx_out, 1'b1);
      check("rst_empty", bus.tx_empty, 1'b1);
      check("rst_full", bus.tx_full, 1'b0);
      check("rst_count", bus.tx_count, 0);
      check("rst_overflow", bus.overflow, 1'b0);
      reset = 1'b1;

      // Cycle-exact single frame of 0xA5: line lags the pop by one cycle.
      d = 8'hA5;
      fb = '1;
      fb[0] = 1'b0;
      for (int i = 0; i < DW; i++) fb[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      fb[1+DW] = ^d;
`endif
      for (int k = 0; k < N_VEC; k++) begin
         vec[k].ld        = (k == 0);
         vec[k].data      = d;
         vec[k].en        = 1'b1;
         vec[k].exp_out   = (k >= 2 && k < 2 + FRAME) ? fb[(k - 2) / CPB] : 1'b1;
         vec[k].exp_empty = (k >= 1 + FRAME);
         vec[k].exp_count = (k == 0) ? 5'd1 : 5'd0;
      end
      for (int k = 0; k < N_VEC; k++) begin
         bus.ld_tx_data = vec[k].ld;
         bus.tx_data    = vec[k].data;
         bus.tx_enable  = vec[k].en;
         tick();
         if (vec[k].ld) exp_q.push_back(vec[k].data);
         check($sformatf("t1_out[%0d]", k), bus.tx_out, vec[k].exp_out);
         check($sformatf("t1_empty[%0d]", k), bus.tx_empty, vec[k].exp_empty);
         check($sformatf("t1_count[%0d]", k), bus.tx_count, vec[k].exp_count);
      end
      bus.ld_tx_data = 1'b0;

      // Three queued words go out back-to-back once enabled.
      bus.tx_enable = 1'b0;
      tick();
      write_word(8'h01, 1);
      write_word(8'h02, 1);
      write_word(8'h03, 1);
      check("t2_count3", bus.tx_count, 3);
      start_q.delete();
      bus.tx_enable = 1'b1;
      tick();
      check("t2_count_pop1", bus.tx_count, 2);
      repeat (FRAME - 1) tick();
      check("t2_count_before_b2b", bus.tx_count, 2);
      tick();
      check("t2_count_b2b", bus.tx_count, 1);
      repeat (FRAME) tick();
      check("t2_count0", bus.tx_count, 0);
      wait_empty(FRAME + 10, "t2_empty");
      check("t2_starts", start_q.size(), 3);
      if (start_q.size() == 3) begin
         check("t2_gap01", start_q[1] - start_q[0], FRAME);
         check("t2_gap12", start_q[2] - start_q[1], FRAME);
      end

      // Fill, overflow, and a pop coinciding with a write while full.
      bus.tx_enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         write_word(8'h10 + 8'(i), 1);
         if (i == 14) begin
            check("t3_full15", bus.tx_full, 1'b0);
            check("t3_count15", bus.tx_count, 15);
         end
      end
      check("t3_full16", bus.tx_full, 1'b1);
      check("t3_count16", bus.tx_count, 16);
      check("t3_ovf_before", bus.overflow, 1'b0);
      write_word(8'hEE, 0);
      check("t3_count_drop", bus.tx_count, 16);
      check("t3_ovf_set", bus.overflow, 1'b1);
      bus.tx_enable = 1'b1;
      write_word(8'hDD, 0);
      check("t3_count_popwr", bus.tx_count, 15);
      check("t3_full_popwr", bus.tx_full, 1'b0);
      check("t3_ovf_sticky", bus.overflow, 1'b1);
      wait_empty(17 * FRAME, "t3_empty");

      // Enable dropped mid-frame: frame completes, next word waits.
      write_word(8'h55, 1);
      write_word(8'h66, 1);
      repeat (14) tick();
      bus.tx_enable = 1'b0;
      repeat (FRAME) tick();
      lows = 0;
      repeat (2 * FRAME) begin
         tick();
         if (bus.tx_out !== 1'b1) lows++;
      end
      check("t4_line_held", lows, 0);
      check("t4_count_held", bus.tx_count, 1);
      check("t4_empty_held", bus.tx_empty, 1'b0);
      bus.tx_enable = 1'b1;
      tick();
      check("t4_resume_pop", bus.tx_count, 0);
      wait_empty(FRAME + 10, "t4_empty");

      // Reset during data bit 3 aborts the frame and clears everything.
      write_word(8'hA5, 1);
      write_word(8'h11, 1);
      write_word(8'h22, 1);
      repeat (16) tick();
      check("t5_count_pre", bus.tx_count, 2);
      check("t5_ovf_pre", bus.overflow, 1'b1);
      reset = 1'b0;
      tick();
      exp_q.delete();
      check("t5_tx_out", bus.tx_out, 1'b1);
      check("t5_empty", bus.tx_empty, 1'b1);
      check("t5_count", bus.tx_count, 0);
      check("t5_ovf", bus.overflow, 1'b0);
      check("t5_full", bus.tx_full, 1'b0);
      tick();
      reset = 1'b1;
      repeat (10) tick();
      check("t5_idle_line", bus.tx_out, 1'b1);
      check("t5_idle_empty", bus.tx_empty, 1'b1);

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: even-sense parity bit 1, odd-sense parity bit 0.
      write_word(8'h07, 1);
      n = 0;
      while (bus.tx_out !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      check("t6_start_seen", bus.tx_out, 1'b0);
      repeat ((1 + DW) * CPB + CPB / 2) tick();
      check("t6_parity_even", bus.tx_out, 1'b1);
      check("t6_parity_odd", bus2.tx_out, 1'b0);
      wait_empty(FRAME + 10, "t6_empty");
`endif

      repeat (5) tick();
      check("frames_outstanding", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
